// File: rtl/lab1_pkg.sv
// Shared types and constants for the lab 1 truth-table sweep sequencer.
package lab1_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Truth table of f = ~B~C~D + ~ABD + BC, bit i at index {A,B,C,D}.
  function automatic logic [15:0] lab1_golden();
    return 16'hC1E1;
  endfunction

endpackage

// File: rtl/lab1_truth_sweep_if.sv
// Control and result bundle between the lab top level and the sweep sequencer.
interface lab1_truth_sweep_if;
  import lab1_pkg::*;

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [15:0]      truth_table;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [IDX_W-1:0] first_fail;
  logic             pass;

  modport master (
    output start, abort,
    input  busy, done, truth_table, mismatch_cnt, first_fail, pass
  );

  modport slave (
    input  start, abort,
    output busy, done, truth_table, mismatch_cnt, first_fail, pass
  );

endinterface

// File: rtl/lab1_settle_timer.sv
// 8-bit loadable down-counter that stops at zero; zero flags the end of settling.
module lab1_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/lab1_truth_sweep.sv
// Drives all 16 input vectors into the function block, captures OUT into a
// truth table and scores it against the golden table.
module lab1_truth_sweep
  import lab1_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'hC1E1
) (
  input  logic               clk,
  input  logic               rst_n,
  lab1_truth_sweep_if.slave  sif,
  input  logic               OUT,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               D
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] vec_q;
  logic [15:0]      tt_q;
  logic [CNT_W-1:0] mcnt_q;
  logic [CNT_W-1:0] mcnt_nxt;
  logic [IDX_W-1:0] ff_q;
  logic             pass_q;
  logic             mism;

  logic tmr_load;
  logic tmr_zero;
  logic do_clear;
  logic do_capture;
  logic do_advance;
  logic do_abort;

  lab1_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort outranks the SAMPLE capture; abort in IDLE or DONE has no effect
  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    do_clear   = 1'b0;
    do_capture = 1'b0;
    do_advance = 1'b0;
    do_abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sif.start) begin
          state_d  = SETTLE;
          tmr_load = 1'b1;
          do_clear = 1'b1;
        end
      end
      SETTLE: begin
        if (sif.abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else if (tmr_zero) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sif.abort) begin
          state_d  = IDLE;
          do_abort = 1'b1;
        end else begin
          do_capture = 1'b1;
          if (idx_q == IDX_W'(15)) begin
            state_d = DONE;
          end else begin
            state_d    = SETTLE;
            tmr_load   = 1'b1;
            do_advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mism     = OUT ^ EXPECTED[idx_q];
  assign mcnt_nxt = mcnt_q + {{(CNT_W-1){1'b0}}, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      vec_q  <= '0;
      tt_q   <= '0;
      mcnt_q <= '0;
      ff_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      if (do_clear) begin
        idx_q  <= '0;
        vec_q  <= '0;
        tt_q   <= '0;
        mcnt_q <= '0;
        ff_q   <= '0;
        pass_q <= 1'b0;
      end
      if (do_capture) begin
        tt_q[idx_q] <= OUT;
        mcnt_q      <= mcnt_nxt;
        if (mism && (mcnt_q == '0)) begin
          ff_q <= idx_q;
        end
        // pass is made valid on entry to DONE so it is readable with done
        if (idx_q == IDX_W'(15)) begin
          pass_q <= (mcnt_nxt == '0);
        end
      end
      if (do_advance) begin
        idx_q <= idx_q + IDX_W'(1);
        vec_q <= idx_q + IDX_W'(1);
      end
      if (do_abort || (state_q == DONE)) begin
        vec_q <= '0;
      end
    end
  end

  assign {A, B, C, D}     = vec_q;
  assign sif.busy         = (state_q != IDLE);
  assign sif.done         = (state_q == DONE);
  assign sif.truth_table  = tt_q;
  assign sif.mismatch_cnt = mcnt_q;
  assign sif.first_fail   = ff_q;
  assign sif.pass         = pass_q;

endmodule

// File: doc/lab1_truth_sweep.md
# lab1_truth_sweep

Sequencer for the four-input combinational function block f = ~B~C~D + ~ABD + BC. On `start` it drives all 16 input vectors {A,B,C,D} in ascending order. It waits a programmable settle time per vector, then captures OUT into a 16-bit truth table and compares the table against a golden constant. It sits between the lab top level (buttons/LEDs or testbench) and the function block, and is the only driver of the block's inputs.

## Interface
- `SETTLE_CYCLES`, default 1: idle cycles per vector before OUT is sampled. Legal range is 1..255.
- `EXPECTED`, default 16'hC1E1: golden truth table. Bit i is f at index i = {A,B,C,D}, with A as the MSB.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep. Sampled only in IDLE.
- `abort` in 1: synchronous cancel of a sweep in progress.
- `OUT` in 1: function block output (combinational).
- `A`, `B`, `C`, `D` out 1 each: registered drive to the function block.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep completes.
- `truth_table` out 16: captured OUT values, bit i for index i.
- `mismatch_cnt` out 5: number of bits where `truth_table` differs from `EXPECTED` (0..16).
- `first_fail` out 4: lowest index that mismatched. Value is 0 when there is no mismatch.
- `pass` out 1: high when `mismatch_cnt` is 0. Valid from `done`.

## Operation
States:
- IDLE: outputs held. `start`=1 moves to SETTLE; it clears `idx`, `truth_table`, `mismatch_cnt`, `first_fail` and `pass`, and drives {A,B,C,D}=0.
- SETTLE: the settle counter counts down from SETTLE_CYCLES-1. When it reaches 0, move to SAMPLE.
- SAMPLE:
  - `truth_table[idx]` ← OUT.
  - On mismatch with `EXPECTED[idx]`: `mismatch_cnt`++. If this is the first mismatch, `first_fail` ← idx.
  - If idx=15, go to DONE. Otherwise idx++, drive the new vector, reload the counter and go to SETTLE.
- DONE: `done`=1 for this cycle only, `pass` ← (`mismatch_cnt`==0). Return to IDLE.

Rules:
- Comparison in SAMPLE uses the OUT captured that cycle. The final `mismatch_cnt` includes index 15.
- `abort`=1 in SETTLE or SAMPLE: go to IDLE next edge. `done` stays 0 and {A,B,C,D} is driven to 0. Partial `truth_table` and `mismatch_cnt` remain visible; `pass` stays 0.
- `abort` takes priority over the SAMPLE capture in the same cycle.
- `start` outside IDLE is ignored; there is no queuing.
- `start` and `abort` asserted together in IDLE: `start` wins; `abort` is a no-op in IDLE.
- `idx` is 4 bits and does not wrap. Termination is by the idx==15 check, never by overflow.
- {A,B,C,D} always equals `idx` while `busy`, and is 4'b0000 otherwise.

## Timing
Reset values, all zero: state=IDLE, A–D=0, `busy`=0, `done`=0, `truth_table`=0, `mismatch_cnt`=0, `first_fail`=0, `pass`=0.

Reset asserted mid-sweep clears everything immediately (asynchronously). No `done` is produced.

Let S = SETTLE_CYCLES. Each vector occupies S+1 cycles: S settle cycles plus 1 sample cycle.

Cycle-level behaviour, with `start` seen at edge k:
- Edge k: `busy`=1, vector 0 is driven.
- Vector i is sampled at the edge ending cycle k+(S+1)(i+1)−1.
- DONE state occupies the cycle after the last sample: `done`=1 and `busy`=1 there.
- `busy` falls with the return to IDLE.
- Total start-to-`done` latency is 16(S+1) cycles.

Results are held stable from `done` until the next accepted `start`.

## Structure
- Package `lab1_pkg`:
  - State enum (IDLE, SETTLE, SAMPLE, DONE).
  - Function `lab1_golden()` returning 16'hC1E1, so testbenches share the constant.
  - `IDX_W`=4 and `CNT_W`=5.
- Sub-module `lab1_settle_timer`: an 8-bit loadable down-counter with `load`, `load_val` and `zero` outputs, instantiated once.
- The main FSM, the capture register and the compare logic stay in the top module.

## Test plan
- Connect the reference function block with S=1 and pulse `start` → `done` at cycle 32 after start. Expect `truth_table`=16'hC1E1, `mismatch_cnt`=0, `pass`=1, `first_fail`=0.
- Tie OUT=0 with S=3 → `done` at cycle 64. Expect `truth_table`=0, `mismatch_cnt`=7, `first_fail`=0, `pass`=0.
- Insert a model with idx 9 forced to 1 → `mismatch_cnt`=1, `first_fail`=9, bit 9 of `truth_table` set.
- Assert `abort` while idx=6 is in SAMPLE → no `done`, `busy` low next cycle, A–D=0. `truth_table[6]` is not written and bits 0–5 are retained. A fresh `start` then gives a clean 16'hC1E1.
- Deassert `rst_n` asynchronously mid-SETTLE → all outputs zero before the next clock edge. Releasing reset and asserting `start` runs a normal sweep.
- Assert `start` during `busy` and in the DONE cycle → both are ignored, and exactly one `done` pulse occurs per accepted start.
